hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage CPU. It generates the stall, write-enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM registers. It covers load-use hazards, taken branches, jumps and multi-cycle data-memory waits. It sits beside the ID stage and drives the ID/EX register's flush input and the upstream register enables.

Parameters:
MEM_TIMEOUT, 255, maximum number of cycles in MEM_WAIT before mem_err is set.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
ID_rs  input  5  rs field of the instruction in ID
ID_rt  input  5  rt field of the instruction in ID
ID_UsesRs  input  1  ID instruction reads rs
ID_UsesRt  input  1  ID instruction reads rt
ID_Jump  input  1  jump decoded in ID (j/jal/jr/jalr)
EX_MemRead  input  1  load currently in EX
EX_WrReg  input  5  destination register of the EX instruction
EX_BranchTaken  input  1  branch resolved taken in EX
MEM_MemRead  input  1  load in MEM
MEM_MemWrite  input  1  store in MEM
mem_ready  input  1  data memory completes the access this cycle
PC_Write  output  1  PC update enable
IF_ID_Write  output  1  IF/ID load enable
IF_ID_Flush  output  1  IF/ID clear to NOP
ID_EX_Flush  output  1  ID/EX clear to bubble
EX_MEM_Hold  output  1  freeze EX/MEM and MEM/WB
mem_err  output  1  sticky memory-timeout flag

Behaviour:
- State machine, states RUN and MEM_WAIT; encoding is in the package. All controls are combinational from the state and inputs.
- While reset is low:
  - state=RUN, timeout counter=0, mem_err=0.
  - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=0, EX_MEM_Hold=0.
- Derived signals:
  - mem_access = MEM_MemRead | MEM_MemWrite.
  - load_use = EX_MemRead & (EX_WrReg != 0) & ((ID_UsesRs & ID_rs==EX_WrReg) | (ID_UsesRt & ID_rt==EX_WrReg)).
- Priority, highest first:
  1. Freeze: (state==MEM_WAIT) or (state==RUN & mem_access & !mem_ready).
     - PC_Write=0, IF_ID_Write=0, EX_MEM_Hold=1, all flushes=0. No other event acts this cycle.
  2. EX_BranchTaken:
     - IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, IF_ID_Write=1.
     - Overrides load_use and ID_Jump, because the ID instruction is squashed.
  3. load_use:
     - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
     - Exactly one bubble: the next cycle EX holds the bubble, so EX_MemRead=0.
  4. ID_Jump: IF_ID_Flush=1, PC_Write=1, IF_ID_Write=1.
  5. Otherwise: PC_Write=1, IF_ID_Write=1, flushes=0, EX_MEM_Hold=0.
- Transitions:
  - RUN->MEM_WAIT when mem_access & !mem_ready; the counter loads 1.
  - In MEM_WAIT the counter increments each cycle and saturates at MEM_TIMEOUT.
  - MEM_WAIT->RUN on the first cycle with mem_ready=1. That cycle is still frozen. The counter clears on exit.
  - Counter reaching MEM_TIMEOUT sets mem_err, which stays set until reset. The state stays MEM_WAIT, so the pipeline hangs visibly.
- A single-cycle access (mem_ready=1 in the same cycle) causes no freeze and no state change.
- Asserting reset in MEM_WAIT returns asynchronously to RUN with all outputs at their reset values.
- mem_ready is ignored when mem_access=0.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cnt[31:0], flush_cnt[31:0] and wait_cnt[31:0].
  - stall_cnt increments on each load_use stall cycle that is actually applied.
  - flush_cnt increments on each cycle with IF_ID_Flush|ID_EX_Flush.
  - wait_cnt increments on each freeze cycle.
  - All three clear on reset and wrap modulo 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package hazard_pkg holds:
  - state encoding localparams ST_RUN=1'b0, ST_MEM_WAIT=1'b1;
  - the REG_ZERO=5'd0 constant;
  - the control-bundle field ordering shared with the pipeline registers.
- One sub-module, hazard_loaduse_detect:
  - combinational load_use compare;
  - reused later by the forwarding unit.
- The FSM, timeout counter and priority mux stay in hazard_ctrl.

Test Plan:
1. lw $t0 in EX (EX_MemRead=1, EX_WrReg=8), ID add with ID_rs=8, ID_UsesRs=1 -> one cycle of PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle all enables 1. Repeat with EX_WrReg=0 -> no stall.
2. load_use and EX_BranchTaken in the same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, no stall.
3. MEM_MemRead=1 with mem_ready low for 3 cycles, then high -> 4 frozen cycles (EX_MEM_Hold=1), return to RUN, counter=0.
4. MEM_MemWrite=1 with mem_ready held low -> mem_err rises after MEM_TIMEOUT=255 wait cycles and stays high; reset low mid-wait -> outputs reset, state RUN, mem_err=0.
5. ID_Jump=1 with no other event -> IF_ID_Flush=1 only. ID_Jump during a freeze -> ignored until the freeze ends.
6. With HAZARD_PERF_CNT_EN defined, run scenarios 1 and 3 -> stall_cnt=1, wait_cnt=4, flush_cnt=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: state encoding,
// register-file constants and the control bundle driven into the pipeline registers.
package hazard_pkg;

   localparam int unsigned REG_W  = 5;
   localparam int unsigned PERF_W = 32;

   localparam logic ST_RUN      = 1'b0;
   localparam logic ST_MEM_WAIT = 1'b1;

   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic {
      RUN      = ST_RUN,
      MEM_WAIT = ST_MEM_WAIT
   } state_t;

   // Field order matches the enable/flush inputs of the pipeline registers
   typedef struct packed {
      logic pcWrite;
      logic ifIdWrite;
      logic ifIdFlush;
      logic idExFlush;
      logic exMemHold;
   } hazard_ctl_t;

   function automatic logic regMatch(input logic uses,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Combinational load-use compare between the ID source operands and the EX load target.
module hazard_loaduse_detect
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             idUsesRs,
   input  logic             idUsesRt,
   input  logic             exMemRead,
   input  logic [REG_W-1:0] exWrReg,
   output logic             loadUse_c
);

   // $zero is never a real dependency
   assign loadUse_c = exMemRead && (exWrReg != REG_ZERO) &&
                      (regMatch(idUsesRs, idRs, exWrReg) || regMatch(idUsesRt, idRt, exWrReg));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush/freeze controller with data-memory wait timeout.
// Optional performance counters enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_W-1:0]  ID_rs,
   input  logic [REG_W-1:0]  ID_rt,
   input  logic              ID_UsesRs,
   input  logic              ID_UsesRt,
   input  logic              ID_Jump,
   input  logic              EX_MemRead,
   input  logic [REG_W-1:0]  EX_WrReg,
   input  logic              EX_BranchTaken,
   input  logic              MEM_MemRead,
   input  logic              MEM_MemWrite,
   input  logic              mem_ready,
   output logic              PC_Write,
   output logic              IF_ID_Write,
   output logic              IF_ID_Flush,
   output logic              ID_EX_Flush,
   output logic              EX_MEM_Hold,
`ifdef HAZARD_PERF_CNT_EN
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt,
   output logic [PERF_W-1:0] wait_cnt,
`endif
   output logic              mem_err
);

   localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

   state_t          state;
   state_t          stateNext;
   logic [TO_W-1:0] toCnt;
   logic [TO_W-1:0] toCntNext;
   logic            memAccess;
   logic            loadUse;
   logic            freeze;
   hazard_ctl_t     ctl;

   hazard_loaduse_detect u_loaduse (
      .idRs      (ID_rs),
      .idRt      (ID_rt),
      .idUsesRs  (ID_UsesRs),
      .idUsesRt  (ID_UsesRt),
      .exMemRead (EX_MemRead),
      .exWrReg   (EX_WrReg),
      .loadUse_c (loadUse)
   );

   assign memAccess = MEM_MemRead | MEM_MemWrite;
   assign freeze    = (state == MEM_WAIT) || ((state == RUN) && memAccess && !mem_ready);

   // Next state and timeout count; count saturates so a hung access stays visible
   always_comb begin
      stateNext = state;
      toCntNext = toCnt;
      case (state)
         RUN: begin
            if (memAccess && !mem_ready) begin
               stateNext = MEM_WAIT;
               toCntNext = TO_W'(1);
            end
         end
         MEM_WAIT: begin
            if (memAccess && mem_ready) begin
               stateNext = RUN;
               toCntNext = '0;
            end else if (toCnt != TO_MAX) begin
               toCntNext = toCnt + TO_W'(1);
            end
         end
         default: begin
            stateNext = RUN;
            toCntNext = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RUN;
         toCnt   <= '0;
         mem_err <= 1'b0;
      end else begin
         state   <= stateNext;
         toCnt   <= toCntNext;
         mem_err <= mem_err | ((stateNext == MEM_WAIT) && (toCntNext == TO_MAX));
      end
   end

   // Priority: freeze > taken branch > load-use bubble > jump > normal flow
   always_comb begin
      ctl = '0;
      if (!reset) begin
         ctl = '0;
      end else if (freeze) begin
         ctl.exMemHold = 1'b1;
      end else if (EX_BranchTaken) begin
         ctl.pcWrite   = 1'b1;
         ctl.ifIdWrite = 1'b1;
         ctl.ifIdFlush = 1'b1;
         ctl.idExFlush = 1'b1;
      end else if (loadUse) begin
         ctl.idExFlush = 1'b1;
      end else if (ID_Jump) begin
         ctl.pcWrite   = 1'b1;
         ctl.ifIdWrite = 1'b1;
         ctl.ifIdFlush = 1'b1;
      end else begin
         ctl.pcWrite   = 1'b1;
         ctl.ifIdWrite = 1'b1;
      end
   end

   assign PC_Write    = ctl.pcWrite;
   assign IF_ID_Write = ctl.ifIdWrite;
   assign IF_ID_Flush = ctl.ifIdFlush;
   assign ID_EX_Flush = ctl.idExFlush;
   assign EX_MEM_Hold = ctl.exMemHold;

`ifdef HAZARD_PERF_CNT_EN
   logic stallApplied;
   assign stallApplied = !freeze && !EX_BranchTaken && loadUse;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
         wait_cnt  <= '0;
      end else begin
         if (stallApplied)                  stall_cnt <= stall_cnt + PERF_W'(1);
         if (ctl.ifIdFlush | ctl.idExFlush) flush_cnt <= flush_cnt + PERF_W'(1);
         if (freeze)                        wait_cnt  <= wait_cnt + PERF_W'(1);
      end
   end
`endif

endmodule
